// File: rtl/fp_11_5_pkg.sv
// Shared layout of the 19-bit 11_5 floating-point word (WE=5, WF=11).
// Used by the fixed-to-float converter and by the FP subtract/compare path.
package fp_11_5_pkg;

    localparam int WE      = 5;
    localparam int WF      = 11;
    localparam int FP_W    = 19;
    localparam int BIAS    = 15;
    // Largest biased exponent a normal number may carry; 31 is not used.
    localparam int EXP_MAX = 30;
    localparam int EXP_MIN = 1;

    // Field positions inside the FP word
    localparam int EXN_HI  = 18;
    localparam int EXN_LO  = 17;
    localparam int SIGN_IX = 16;
    localparam int EXP_HI  = 15;
    localparam int EXP_LO  = 11;
    localparam int FRAC_HI = 10;
    localparam int FRAC_LO = 0;

    // Exception codes
    typedef enum logic [1:0] {
        EXN_ZERO   = 2'b00,
        EXN_NORMAL = 2'b01,
        EXN_INF    = 2'b10,
        EXN_NAN    = 2'b11
    } exn_t;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        NORM = 2'b01,
        PACK = 2'b10,
        OUT  = 2'b11
    } state_t;

    // Word view matching the field positions above
    typedef struct packed {
        exn_t          exn;
        logic          sign;
        logic [WE-1:0] expo;
        logic [WF-1:0] frac;
    } fp_word_t;

endpackage

// File: rtl/fix_to_fp_11_5.sv
// Serial signed fixed-point to 11_5 floating-point converter.
// The magnitude is normalised one bit per cycle; valid/ready on both sides.
module fix_to_fp_11_5
    import fp_11_5_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [FP_W-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready
);

    // Shift count holds 0..IN_W-1
    localparam int SW = $clog2(IN_W) + 1;
    // Biased exponent when the magnitude MSB is already set (s = 0)
    localparam int EXP_TOP = IN_W - 1 - FRAC_BITS + BIAS;

    state_t            state_reg;
    state_t            state_next;
    logic              sign_reg;
    logic [IN_W-1:0]   mag_reg;
    logic [SW-1:0]     s_reg;
    logic [FP_W-1:0]   out_data_reg;
    logic              out_valid_reg;

    logic              load_en;
    logic              shift_en;
    logic              pack_en;
    logic              release_en;
    logic              norm_done;
    logic [IN_W-1:0]   in_mag;
    logic signed [15:0] biased;
    fp_word_t          packed_word;

    // Most negative input maps to 2^(IN_W-1), which fits unsigned IN_W bits
    assign in_mag    = in_data[IN_W-1] ? ((~in_data) + IN_W'(1)) : in_data;
    assign norm_done = (mag_reg == '0) || mag_reg[IN_W-1];
    assign biased    = 16'(EXP_TOP) - 16'(s_reg);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = NORM;
            NORM:    if (norm_done) state_next = PACK;
            PACK:    state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-state control strobes and the ready flag
    always_comb begin
        load_en    = 1'b0;
        shift_en   = 1'b0;
        pack_en    = 1'b0;
        release_en = 1'b0;
        in_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = ~rst;
                load_en  = in_valid;
            end
            NORM:    shift_en   = ~norm_done;
            PACK:    pack_en    = 1'b1;
            OUT:     release_en = out_ready;
            default: ;
        endcase
    end

    // Field encoding from the normalised magnitude and shift count
    always_comb begin
        packed_word = '0;
        if (mag_reg == '0) begin
            packed_word = '0;
        end else if (biased > $signed(16'(EXP_MAX))) begin
            packed_word.exn  = EXN_INF;
            packed_word.sign = sign_reg;
        end else if (biased < $signed(16'(EXP_MIN))) begin
            // Too small to represent: flush to an unsigned zero
            packed_word = '0;
        end else begin
            packed_word.exn  = EXN_NORMAL;
            packed_word.sign = sign_reg;
            packed_word.expo = biased[WE-1:0];
            // Hidden one dropped, remaining low bits truncated
            packed_word.frac = mag_reg[IN_W-2 -: WF];
        end
    end

    // Operand capture, serial normalisation and output holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_reg      <= 1'b0;
            mag_reg       <= '0;
            s_reg         <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (load_en) begin
                sign_reg <= in_data[IN_W-1];
                mag_reg  <= in_mag;
                s_reg    <= '0;
            end
            if (shift_en) begin
                mag_reg <= {mag_reg[IN_W-2:0], 1'b0};
                s_reg   <= s_reg + SW'(1);
            end
            if (pack_en) begin
                out_data_reg  <= packed_word;
                out_valid_reg <= 1'b1;
            end
            if (release_en) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: doc/fix_to_fp_11_5.md
# fix_to_fp_11_5

Sequential converter from signed two's-complement fixed-point to the 19-bit FloPoCo-style 11_5 floating-point word (WE=5, WF=11) used by the FP subtract and compare path. It is the producing end of that format: it encodes the exception, sign, exponent and fraction fields that the comparator decodes. It sits between the fixed-point ray/box coordinate sources and the FP datapath. It normalises with one bit shift per cycle, and uses a valid/ready handshake on both sides.

## Interface
- IN_W, 16, input word width; legal range 12..32
- FRAC_BITS, 8, number of fractional bits in the input; value = in_data / 2^FRAC_BITS
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  reset; synchronous, active-high
- in_data  input  IN_W  signed fixed-point operand
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts an operand; high only in IDLE
- out_data  output  19  FP word: [18:17] exn, [16] sign, [15:11] biased exponent, [10:0] fraction
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer takes out_data

## Operation
- exn codes: 00 zero, 01 normal, 10 infinity; 11 (NaN) is never produced. Bias is 15. The hidden leading 1 is not stored.
- FSM states:
  - IDLE: in_ready=1. On in_valid, register sign=in_data[IN_W-1] and mag=|in_data| (IN_W-bit unsigned; the most negative input gives 2^(IN_W-1) exactly), clear shift count s, go to NORM.
  - NORM: if mag==0 or mag[IN_W-1]==1, go to PACK. Otherwise mag<<=1, s+=1, stay.
  - PACK: write out_data, set out_valid, go to OUT.
  - OUT: hold out_data and out_valid. When out_ready=1, clear out_valid and go to IDLE.
- Exponent: e = (IN_W-1-s) - FRAC_BITS; biased = e+15, computed signed with at least 7 bits.
- Fraction: mag[IN_W-2 -: 11]. Remaining low bits are truncated (round toward zero).
- Special results:
  - mag==0: out_data = all zeros (exn 00, sign 0).
  - biased > 30: exn 10, sign kept, exponent and fraction zero.
  - biased < 1: flush to zero; exn 00, sign 0, rest zero.
- Output holds stable while out_valid=1 and out_ready=0.
- in_valid is ignored outside IDLE; the source must hold in_data until the accepting edge.

## Timing
- Reset values: out_data=0, out_valid=0, state IDLE, s=0. in_ready=0 while rst=1, and 1 from the first cycle after rst deasserts.
- Latency: out_valid rises 2+s edges after the accepting edge. s is the leading-zero count of mag, 0..IN_W-1, and s=0 for a zero input.
  - Minimum latency is 2 (magnitude MSB already set, or zero input).
  - Maximum latency is IN_W+1 (mag==1).
- Handshake: transfer occurs on an edge where out_valid and out_ready are both 1. The next operand can be accepted one cycle later, in IDLE.
- Throughput: one result per 4+s cycles with out_ready tied high.
- rst mid-conversion or in OUT: abandon the operand, clear out_valid and out_data on that edge, return to IDLE. No partial result is ever presented.
- out_ready=1 while out_valid=0 has no effect.

## Structure
- Shared package fp_11_5_pkg holds:
  - WE=5, WF=11, FP_W=19, BIAS=15
  - exn codes EXN_ZERO, EXN_NORMAL, EXN_INF, EXN_NAN
  - field index constants for exn, sign, exponent and fraction
  - the state enum (IDLE, NORM, PACK, OUT), so the comparator and future FP blocks share the layout
- Single module, no sub-module. The shifter is the serial NORM loop, not a priority encoder.

## Test plan
- Default params, out_ready=1:
  - in 0x0100 (1.0) -> out_data 0x27800 (exn 01, exp 01111, frac 0), out_valid 9 edges after accept
  - in 0xFE80 (-1.5) -> 0x37C00, latency 9
  - in 0x0001 (2^-8) -> 0x23800, latency 17 (maximum)
- in 0x8000 (-128) -> 0x3B000, latency 2. in 0x0000 -> 0x00000, latency 2.
- Truncation: in 0x7FFF -> 0x2AFFF, latency 3. Low 3 bits are dropped and no rounding up occurs.
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - out_data is stable and in_ready stays 0 throughout.
  - An in_valid pulse during this time is not accepted.
  - Release -> IDLE next cycle.
- Reset: assert rst during NORM on input 0x0001.
  - Next cycle: out_valid=0, out_data=0, in_ready=1 after rst deasserts.
  - A following 0x0100 converts to 0x27800.
- Cross-check: feed converted pairs of random fixed-point values into the FP subtract/compare path. The less flag must equal the signed compare of the raw inputs whenever truncation does not collapse the two values.
